// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access widths, FSM states, lane math.
package load_store_unit_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned LOG_MEM_SIZE_WORDS = 14;
  localparam int unsigned BYTE_LANES         = XLEN / 8;
  localparam int unsigned IDX_W              = XLEN - 2;

  typedef enum logic [1:0] {
    WRITE_BYTE = 2'd0,
    WRITE_HALF = 2'd1,
    WRITE_WORD = 2'd2
  } write_width_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } lsu_state_t;

  function automatic logic [2:0] width_bytes(input write_width_t w);
    case (w)
      WRITE_BYTE: return 3'd1;
      WRITE_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] width_mask(input write_width_t w);
    case (w)
      WRITE_BYTE: return XLEN'(8'hFF);
      WRITE_HALF: return XLEN'(16'hFFFF);
      default:    return {XLEN{1'b1}};
    endcase
  endfunction

  // An access is misaligned when its bytes spill past the end of the addressed word.
  function automatic logic is_misaligned(input write_width_t w, input logic [1:0] off);
    return (4'(off) + 4'(width_bytes(w))) > 4'(BYTE_LANES);
  endfunction

  function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] addr);
    return {2'b00, addr[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute stage (master) and the load/store unit (slave).
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  write_width_t        req_width;
  logic                req_unsigned;
  logic [XLEN-1:0]     req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic                resp_valid;
  logic [XLEN-1:0]     resp_rdata;
  logic                resp_fault;

  modport master (
    output req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend across one or two words, and store lane merge
// for the word selected by hi_phase.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]      offset,
  input  write_width_t    width,
  input  logic            is_unsigned,
  input  logic            hi_phase,
  input  logic [XLEN-1:0] cur_word,
  input  logic [XLEN-1:0] prev_word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged_word
);

  logic [2*XLEN-1:0] rd_pair;
  logic [2*XLEN-1:0] wr_shifted;
  logic [2*XLEN-1:0] wr_mask;
  logic [XLEN-1:0]   lane_mask;
  logic [XLEN-1:0]   rd_field;
  logic [XLEN-1:0]   word_data;
  logic [XLEN-1:0]   word_mask;
  logic [4:0]        shamt;

  always_comb begin
    shamt     = {offset, 3'b000};
    lane_mask = width_mask(width);

    // In the high phase the previously captured low word sits below the current one.
    rd_pair  = hi_phase ? {cur_word, prev_word} : {XLEN'(0), cur_word};
    rd_field = XLEN'(rd_pair >> shamt) & lane_mask;

    load_data = rd_field;
    if (!is_unsigned) begin
      case (width)
        WRITE_BYTE: load_data = {{(XLEN-8){rd_field[7]}}, rd_field[7:0]};
        WRITE_HALF: load_data = {{(XLEN-16){rd_field[15]}}, rd_field[15:0]};
        default:    load_data = rd_field;
      endcase
    end

    wr_shifted  = {XLEN'(0), wdata & lane_mask} << shamt;
    wr_mask     = {XLEN'(0), lane_mask} << shamt;
    word_data   = hi_phase ? wr_shifted[2*XLEN-1:XLEN] : wr_shifted[XLEN-1:0];
    word_mask   = hi_phase ? wr_mask[2*XLEN-1:XLEN]    : wr_mask[XLEN-1:0];
    merged_word = (cur_word & ~word_mask) | (word_data & word_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Hart-side load/store initiator for the word-addressed data memory.
// Define LSU_MISALIGN_SPLIT_EN to run misaligned accesses as two word phases instead of faulting.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  load_store_unit_if.slave   lsu,
  output logic [XLEN-1:0]    mem_waddr,
  output logic [XLEN-1:0]    mem_raddr,
  output write_width_t       mem_wwidth,
  output logic               mem_wenable,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic [XLEN-1:0]    mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_t      state_q, state_d;
  logic            write_q, write_d;
  write_width_t    width_q, width_d;
  logic            unsigned_q, unsigned_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            phase_q, phase_d;
  logic [XLEN-1:0] lo_word_q, lo_word_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_fault_q, resp_fault_d;
  logic [XLEN-1:0] mem_waddr_q, mem_waddr_d;
  logic [XLEN-1:0] mem_raddr_q, mem_raddr_d;
  write_width_t    mem_wwidth_q, mem_wwidth_d;
  logic            mem_wenable_q, mem_wenable_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic            accept;
  logic [1:0]      req_off;
  logic            req_mis;
  logic            last_phase;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  lsu_lane_align u_align (
    .offset      (addr_q[1:0]),
    .width       (width_q),
    .is_unsigned (unsigned_q),
    .hi_phase    (phase_q),
    .cur_word    (mem_rdata),
    .prev_word   (lo_word_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    accept     = lsu.req_valid && req_ready_q;
    req_off    = lsu.req_addr[1:0];
    req_mis    = is_misaligned(lsu.req_width, req_off);
    // Only a split access has a second phase still to run after phase 0.
    last_phase = !(SPLIT_EN && is_misaligned(width_q, addr_q[1:0])) || phase_q;
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    width_d      = width_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    phase_d      = phase_q;
    lo_word_d    = lo_word_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    mem_waddr_d  = mem_waddr_q;
    mem_raddr_d  = mem_raddr_q;
    mem_wwidth_d = mem_wwidth_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d    = lsu.req_write;
          width_d    = lsu.req_width;
          unsigned_d = lsu.req_unsigned;
          addr_d     = lsu.req_addr;
          wdata_d    = lsu.req_wdata;
          phase_d    = 1'b0;
          if (req_mis && !SPLIT_EN) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
          end else if (lsu.req_write && (req_off == 2'd0)) begin
            state_d      = WR;
            mem_waddr_d  = word_index(lsu.req_addr);
            mem_wwidth_d = lsu.req_width;
            mem_wdata_d  = lsu.req_wdata;
          end else begin
            state_d     = RD_ADDR;
            mem_raddr_d = word_index(lsu.req_addr);
          end
        end
      end

      RD_ADDR: state_d = RD_DATA;

      RD_DATA: begin
        if (write_q) begin
          state_d      = WR;
          mem_waddr_d  = mem_raddr_q;
          mem_wwidth_d = WRITE_WORD;
          mem_wdata_d  = merged_word;
        end else if (!last_phase) begin
          state_d     = RD_ADDR;
          phase_d     = 1'b1;
          lo_word_d   = mem_rdata;
          mem_raddr_d = {2'b00, addr_q[XLEN-1:2] + IDX_W'(1)};
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = load_data;
        end
      end

      WR: begin
        if (!last_phase) begin
          state_d     = RD_ADDR;
          phase_d     = 1'b1;
          mem_raddr_d = {2'b00, addr_q[XLEN-1:2] + IDX_W'(1)};
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = '0;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_wenable_d = (state_d == WR);
    req_ready_d   = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      width_q       <= WRITE_BYTE;
      unsigned_q    <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      phase_q       <= 1'b0;
      lo_word_q     <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_fault_q  <= 1'b0;
      mem_waddr_q   <= '0;
      mem_raddr_q   <= '0;
      mem_wwidth_q  <= WRITE_BYTE;
      mem_wenable_q <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      width_q       <= width_d;
      unsigned_q    <= unsigned_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      phase_q       <= phase_d;
      lo_word_q     <= lo_word_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_fault_q  <= resp_fault_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_raddr_q   <= mem_raddr_d;
      mem_wwidth_q  <= mem_wwidth_d;
      mem_wenable_q <= mem_wenable_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign lsu.req_ready  = req_ready_q;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_fault = resp_fault_q;
  assign mem_waddr      = mem_waddr_q;
  assign mem_raddr      = mem_raddr_q;
  assign mem_wwidth     = mem_wwidth_q;
  assign mem_wenable    = mem_wenable_q;
  assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed table, reset/backpressure sequences, random vs byte model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  load_store_unit_if lsu ();
  logic [31:0]  mem_waddr, mem_raddr, mem_wdata, mem_rdata;
  write_width_t mem_wwidth;
  logic         mem_wenable;

  load_store_unit u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .lsu         (lsu),
    .mem_waddr   (mem_waddr),
    .mem_raddr   (mem_raddr),
    .mem_wwidth  (mem_wwidth),
    .mem_wenable (mem_wenable),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Word memory with aliasing above LOG_MEM_SIZE_WORDS, lane-0-based write widths.
  bit [31:0] mem [1 << LOG_MEM_SIZE_WORDS];
  always @(posedge clock) begin
    mem_rdata <= mem[mem_raddr[LOG_MEM_SIZE_WORDS-1:0]];
    if (mem_wenable) begin
      case (mem_wwidth)
        WRITE_BYTE: mem[mem_waddr[LOG_MEM_SIZE_WORDS-1:0]][7:0]  = mem_wdata[7:0];
        WRITE_HALF: mem[mem_waddr[LOG_MEM_SIZE_WORDS-1:0]][15:0] = mem_wdata[15:0];
        default:    mem[mem_waddr[LOG_MEM_SIZE_WORDS-1:0]]       = mem_wdata;
      endcase
    end
  end

  // Reference: flat little-endian byte space of the aliased memory.
  bit [7:0] ref_bytes [1 << (LOG_MEM_SIZE_WORDS + 2)];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic void ref_access(input logic wr, input write_width_t w, input logic uns,
                                     input logic [31:0] a, input logic [31:0] d,
                                     output logic [31:0] rdata, output logic fault,
                                     output int lat, output int nwr);
    int n;
    int words;
    logic [31:0] v;
    n     = (w == WRITE_BYTE) ? 1 : (w == WRITE_HALF) ? 2 : 4;
    words = (int'(a[1:0]) + n > 4) ? 2 : 1;
    rdata = '0;
    fault = 1'b0;
    nwr   = 0;
    if (words == 2 && !SPLIT) begin
      fault = 1'b1;
      lat   = 1;
    end else if (wr) begin
      for (int k = 0; k < n; k++) ref_bytes[16'(a + 32'(k))] = d[8*k +: 8];
      nwr = words;
      lat = (a[1:0] == 2'd0) ? 2 : 3 * words + 1;
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_bytes[16'(a + 32'(k))];
      if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      rdata = v;
      lat   = 2 * words + 1;
    end
  endfunction

  task automatic run_txn(input logic wr, input write_width_t w, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output logic fault, output int lat,
                         output int nwr, output logic [31:0] waddr, output write_width_t wwidth,
                         output logic [31:0] wdata);
    int guard = 0;
    @(negedge clock);
    while (!lsu.req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    lsu.req_valid    = 1'b1;
    lsu.req_write    = wr;
    lsu.req_width    = w;
    lsu.req_unsigned = uns;
    lsu.req_addr     = a;
    lsu.req_wdata    = d;
    rdata = '0; fault = 1'b0; lat = -1; nwr = 0;
    waddr = '0; wwidth = WRITE_BYTE; wdata = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      lsu.req_valid = 1'b0;
      if (mem_wenable) begin
        nwr++;
        waddr  = mem_waddr;
        wwidth = mem_wwidth;
        wdata  = mem_wdata;
      end
      if (lsu.resp_valid) begin
        lat   = c;
        rdata = lsu.resp_rdata;
        fault = lsu.resp_fault;
        break;
      end
    end
  endtask

  typedef struct {
    logic         wr;
    write_width_t w;
    logic         uns;
    logic [31:0]  a, d, er;
    logic         ef;
    int           el, en;
    logic [31:0]  ewa;
    write_width_t eww;
    logic [31:0]  ewd;
  } vec_t;

  function automatic vec_t mk(input logic wr, input write_width_t w, input logic uns,
                              input logic [31:0] a, input logic [31:0] d, input logic [31:0] er,
                              input logic ef, input int el, input int en,
                              input logic [31:0] ewa, input write_width_t eww,
                              input logic [31:0] ewd);
    vec_t v;
    v.wr = wr; v.w = w; v.uns = uns; v.a = a; v.d = d; v.er = er; v.ef = ef;
    v.el = el; v.en = en; v.ewa = ewa; v.eww = eww; v.ewd = ewd;
    return v;
  endfunction

  vec_t vecs [18];

  initial begin
    logic [31:0]  rdata, waddr, wdata, er;
    logic         fault, ef;
    int           lat, nwr, el, en;
    write_width_t wwidth, rw;
    logic [4:0]   ready_bits;
    int           resp_cnt, resp1_cyc, resp2_cyc, bad_cycles;
    logic [31:0]  resp1_data, resp2_data, a, d;
    logic         rwr, runs;

    vecs[0]  = mk(1, WRITE_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2, 1, 32'h4, WRITE_WORD, 32'hDEADBEEF);
    vecs[1]  = mk(0, WRITE_WORD, 0, 32'h10, 0, 32'hDEADBEEF, 0, 3, 0, 0, WRITE_BYTE, 0);
    vecs[2]  = mk(1, WRITE_BYTE, 0, 32'h13, 32'h000000AB, 0, 0, 4, 1, 32'h4, WRITE_WORD, 32'hABADBEEF);
    vecs[3]  = mk(0, WRITE_WORD, 0, 32'h10, 0, 32'hABADBEEF, 0, 3, 0, 0, WRITE_BYTE, 0);
    vecs[4]  = mk(0, WRITE_BYTE, 0, 32'h13, 0, 32'hFFFFFFAB, 0, 3, 0, 0, WRITE_BYTE, 0);
    vecs[5]  = mk(0, WRITE_BYTE, 1, 32'h13, 0, 32'h000000AB, 0, 3, 0, 0, WRITE_BYTE, 0);
    vecs[6]  = mk(0, WRITE_HALF, 0, 32'h12, 0, 32'hFFFFABAD, 0, 3, 0, 0, WRITE_BYTE, 0);
    vecs[7]  = mk(1, WRITE_WORD, 0, 32'h10, 32'h44332211, 0, 0, 2, 1, 32'h4, WRITE_WORD, 32'h44332211);
    vecs[8]  = mk(1, WRITE_WORD, 0, 32'h14, 32'h88776655, 0, 0, 2, 1, 32'h5, WRITE_WORD, 32'h88776655);
    vecs[9]  = mk(0, WRITE_WORD, 0, 32'h11, 0, SPLIT ? 32'h55443322 : 32'h0, !SPLIT,
                  SPLIT ? 5 : 1, 0, 0, WRITE_BYTE, 0);
    vecs[10] = mk(0, WRITE_HALF, 1, 32'h16, 0, 32'h00008877, 0, 3, 0, 0, WRITE_BYTE, 0);
    vecs[11] = mk(0, WRITE_HALF, 0, 32'h16, 0, 32'hFFFF8877, 0, 3, 0, 0, WRITE_BYTE, 0);
    vecs[12] = mk(1, WRITE_HALF, 0, 32'h15, 32'h0000CAFE, 0, 0, 4, 1, 32'h5, WRITE_WORD, 32'h88CAFE55);
    vecs[13] = mk(0, WRITE_HALF, 0, 32'h13, 0, SPLIT ? 32'h00005544 : 32'h0, !SPLIT,
                  SPLIT ? 5 : 1, 0, 0, WRITE_BYTE, 0);
    vecs[14] = mk(1, WRITE_BYTE, 0, 32'h14, 32'h1234567F, 0, 0, 2, 1, 32'h5, WRITE_BYTE, 32'h1234567F);
    vecs[15] = mk(0, WRITE_WORD, 0, 32'h14, 0, 32'h88CAFE7F, 0, 3, 0, 0, WRITE_BYTE, 0);
    vecs[16] = mk(1, WRITE_HALF, 0, 32'h10, 32'hFFFFBEEF, 0, 0, 2, 1, 32'h4, WRITE_HALF, 32'hFFFFBEEF);
    vecs[17] = mk(0, WRITE_WORD, 0, 32'h10, 0, 32'h4433BEEF, 0, 3, 0, 0, WRITE_BYTE, 0);

    lsu.req_valid = 1'b0; lsu.req_write = 1'b0; lsu.req_width = WRITE_BYTE;
    lsu.req_unsigned = 1'b0; lsu.req_addr = '0; lsu.req_wdata = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    check("reset req_ready", 32'(lsu.req_ready), 32'd1);
    check("reset resp_valid", 32'(lsu.resp_valid), 32'd0);
    check("reset resp_rdata", lsu.resp_rdata, 32'd0);
    check("reset resp_fault", 32'(lsu.resp_fault), 32'd0);
    check("reset mem_wenable", 32'(mem_wenable), 32'd0);
    check("reset mem_addrs", mem_waddr | mem_raddr | mem_wdata, 32'd0);

    for (int i = 0; i < 18; i++) begin
      run_txn(vecs[i].wr, vecs[i].w, vecs[i].uns, vecs[i].a, vecs[i].d,
              rdata, fault, lat, nwr, waddr, wwidth, wdata);
      ref_access(vecs[i].wr, vecs[i].w, vecs[i].uns, vecs[i].a, vecs[i].d, er, ef, el, en);
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].er);
      check($sformatf("vec%0d fault", i), 32'(fault), 32'(vecs[i].ef));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].el));
      check($sformatf("vec%0d writes", i), 32'(nwr), 32'(vecs[i].en));
      if (vecs[i].en > 0) begin
        check($sformatf("vec%0d waddr", i), waddr, vecs[i].ewa);
        check($sformatf("vec%0d wwidth", i), 32'(wwidth), 32'(vecs[i].eww));
        check($sformatf("vec%0d wdata", i), wdata, vecs[i].ewd);
      end
    end

    // Reset during RD_DATA of an RMW store: nothing is written, unit returns idle.
    @(negedge clock);
    lsu.req_valid = 1'b1; lsu.req_write = 1'b1; lsu.req_width = WRITE_BYTE;
    lsu.req_addr = 32'h11; lsu.req_wdata = 32'h99;
    @(negedge clock);
    lsu.req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst async req_ready", 32'(lsu.req_ready), 32'd1);
    bad_cycles = 0;
    repeat (3) begin
      @(negedge clock);
      if (mem_wenable || lsu.resp_valid) bad_cycles++;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (mem_wenable || lsu.resp_valid) bad_cycles++;
    end
    check("rst no write/resp", 32'(bad_cycles), 32'd0);
    check("rst req_ready after", 32'(lsu.req_ready), 32'd1);
    check("rst memory word4", mem[4], 32'h4433BEEF);
    run_txn(0, WRITE_WORD, 0, 32'h10, 0, rdata, fault, lat, nwr, waddr, wwidth, wdata);
    check("rst reload data", rdata, 32'h4433BEEF);
    check("rst reload latency", 32'(lat), 32'd3);

    // req_valid held through a busy load; the next request is taken right after RESP.
    @(negedge clock);
    lsu.req_valid = 1'b1; lsu.req_write = 1'b0; lsu.req_width = WRITE_WORD;
    lsu.req_unsigned = 1'b0; lsu.req_addr = 32'h10;
    ready_bits = '0; resp_cnt = 0; resp1_cyc = -1; resp2_cyc = -1;
    resp1_data = '0; resp2_data = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 1) lsu.req_addr = 32'h14;
      if (c == 5) lsu.req_valid = 1'b0;
      if (c <= 5) ready_bits[5-c] = lsu.req_ready;
      if (lsu.resp_valid) begin
        if (resp_cnt == 0) begin resp1_cyc = c; resp1_data = lsu.resp_rdata; end
        else begin resp2_cyc = c; resp2_data = lsu.resp_rdata; end
        resp_cnt++;
      end
    end
    check("hold ready pattern", 32'(ready_bits), 32'b00010);
    check("hold resp1 cycle", 32'(resp1_cyc), 32'd3);
    check("hold resp1 data", resp1_data, 32'h4433BEEF);
    check("hold resp2 cycle", 32'(resp2_cyc), 32'd7);
    check("hold resp2 data", resp2_data, 32'h88CAFE7F);
    check("hold resp count", 32'(resp_cnt), 32'd2);

    // Random traffic over words 0..32, with aliased upper address bits.
    for (int i = 0; i < 34; i++) begin
      d = $urandom;
      run_txn(1, WRITE_WORD, 0, 32'(4 * i), d, rdata, fault, lat, nwr, waddr, wwidth, wdata);
      ref_access(1, WRITE_WORD, 0, 32'(4 * i), d, er, ef, el, en);
    end
    for (int i = 0; i < 300; i++) begin
      rwr  = 1'($urandom_range(0, 1));
      rw   = write_width_t'(2'($urandom_range(0, 2)));
      runs = 1'($urandom_range(0, 1));
      a    = (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 127));
      d    = $urandom;
      run_txn(rwr, rw, runs, a, d, rdata, fault, lat, nwr, waddr, wwidth, wdata);
      ref_access(rwr, rw, runs, a, d, er, ef, el, en);
      check($sformatf("rand%0d rdata a=%h", i, a), rdata, er);
      check($sformatf("rand%0d fault a=%h", i, a), 32'(fault), 32'(ef));
      check($sformatf("rand%0d latency a=%h", i, a), 32'(lat), 32'(el));
      check($sformatf("rand%0d writes a=%h", i, a), 32'(nwr), 32'(en));
    end
    for (int i = 0; i < 34; i++) begin
      check($sformatf("memword%0d", i), mem[i],
            {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
